// File: rtl/stream_bit_unpack_pkg.sv
// Shared types and defaults for the streaming coefficient unpacker.
// Holds mode/state enums and the words-per-polynomial helper.
package athestia_unpack_pkg;

    localparam int DEF_IN_W       = 32;
    localparam int DEF_MAX_BITLEN = 20;
    localparam int DEF_COEF_W     = 24;
    localparam int DEF_N_COEF     = 256;

    typedef enum logic {
        MODE_SIMPLE = 1'b0,
        MODE_SUB_B  = 1'b1
    } unpack_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } unpack_state_e;

    // Input words needed to carry one polynomial; bit counts are exact.
    function automatic int words_per_poly(
        input int n_coef,
        input int bitlen,
        input int in_w
    );
        return (n_coef * bitlen) / in_w;
    endfunction

endpackage

// File: rtl/stream_bit_unpack_shift_buffer.sv
// Variable-width append/extract bit buffer with fill count.
// Words append above the valid bits; coefficients drain from the bottom.
module unpack_shift_buffer #(
    parameter int IN_W       = 32,
    parameter int MAX_BITLEN = 20,
    parameter int BL_W       = $clog2(MAX_BITLEN + 1),
    parameter int CNT_W      = $clog2(IN_W + MAX_BITLEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [BL_W-1:0]       bitlen,
    input  logic                  fill,
    input  logic [IN_W-1:0]       word,
    input  logic                  drain,
    output logic [MAX_BITLEN-1:0] raw,
    output logic [CNT_W-1:0]      cnt
);

    localparam int CAP = IN_W + MAX_BITLEN - 1;

    logic [CAP-1:0]        data_q;
    logic [CAP-1:0]        data_d;
    logic [CAP-1:0]        kept;
    logic [CAP-1:0]        word_ext;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      cnt_kept;
    logic [MAX_BITLEN:0]   one_hot;
    logic [MAX_BITLEN:0]   mask;

    // Drain first, then append the new word above what remains.
    always_comb begin
        kept     = data_q;
        cnt_kept = cnt_q;
        if (drain) begin
            kept     = data_q >> bitlen;
            cnt_kept = cnt_q - CNT_W'(bitlen);
        end
        word_ext = {{(CAP - IN_W){1'b0}}, word};
        data_d   = kept;
        cnt_d    = cnt_kept;
        if (fill) begin
            data_d = kept | (word_ext << cnt_kept);
            cnt_d  = cnt_kept + CNT_W'(IN_W);
        end
        if (clear) begin
            data_d = '0;
            cnt_d  = '0;
        end
    end

    // Buffer contents and fill count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // Low bitlen bits of the buffer form the current raw coefficient.
    always_comb begin
        one_hot = {{MAX_BITLEN{1'b0}}, 1'b1} << bitlen;
        mask    = one_hot - 1'b1;
        raw     = data_q[MAX_BITLEN-1:0] & mask[MAX_BITLEN-1:0];
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/stream_bit_unpack.sv
// Streaming unpacker: packed words in, one coefficient per handshake out.
// Optional UNPACK_RANGE_CHECK_EN flags raw > 2*b in subtract mode.
module stream_bit_unpack
    import athestia_unpack_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int MAX_BITLEN = DEF_MAX_BITLEN,
    parameter int COEF_W     = DEF_COEF_W,
    parameter int N_COEF     = DEF_N_COEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [$clog2(MAX_BITLEN+1)-1:0]   cfg_bitlen,
    input  logic                              cfg_mode,
    input  logic [COEF_W-1:0]                 cfg_b,
    input  logic [IN_W-1:0]                   in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [COEF_W-1:0]                 coef,
    output logic [$clog2(N_COEF)-1:0]         coef_idx,
    output logic                              coef_valid,
    input  logic                              coef_ready,
    output logic                              coef_last,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int BL_W  = $clog2(MAX_BITLEN + 1);
    localparam int IDX_W = $clog2(N_COEF);
    localparam int CAP   = IN_W + MAX_BITLEN - 1;
    localparam int CNT_W = $clog2(CAP + 1);
    localparam int WL_W  = $clog2(N_COEF * MAX_BITLEN / IN_W + 1);

    unpack_state_e          state_q;
    unpack_state_e          state_d;
    logic [BL_W-1:0]        bitlen_q;
    unpack_mode_e           mode_q;
    logic [COEF_W-1:0]      b_q;
    logic [WL_W-1:0]        words_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   err_q;

    logic                   cfg_legal;
    logic                   start_ok;
    logic                   start_bad;
    logic                   run;
    logic                   word_hs;
    logic                   coef_hs;
    logic                   range_bad;
    logic [MAX_BITLEN-1:0]  raw;
    logic [COEF_W-1:0]      raw_ext;
    logic [CNT_W-1:0]       cnt;

    assign cfg_legal = (cfg_bitlen != '0)
                    && (cfg_bitlen <= BL_W'(MAX_BITLEN));
    assign start_ok  = start && (state_q == IDLE) && cfg_legal;
    assign start_bad = start && (state_q == IDLE) && !cfg_legal;
    assign run       = (state_q == RUN);

    assign in_ready   = run
                     && (int'(cnt) + IN_W <= CAP)
                     && (words_q != '0);
    assign coef_valid = run && (cnt >= CNT_W'(bitlen_q));
    assign word_hs    = in_valid && in_ready;
    assign coef_hs    = coef_valid && coef_ready;

    unpack_shift_buffer #(
        .IN_W       (IN_W),
        .MAX_BITLEN (MAX_BITLEN),
        .BL_W       (BL_W),
        .CNT_W      (CNT_W)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok),
        .bitlen (bitlen_q),
        .fill   (word_hs),
        .word   (in_data),
        .drain  (coef_hs),
        .raw    (raw),
        .cnt    (cnt)
    );

    assign raw_ext = {{(COEF_W - MAX_BITLEN){1'b0}}, raw};

    // Coefficient derives from held registers, so it stays put while stalled.
    always_comb begin
        coef = raw_ext;
        if (mode_q == MODE_SUB_B) begin
            coef = b_q - raw_ext;
        end
    end

`ifdef UNPACK_RANGE_CHECK_EN
    assign range_bad = (mode_q == MODE_SUB_B)
                    && ({1'b0, raw_ext} > {b_q, 1'b0});
`else
    assign range_bad = 1'b0;
`endif

    assign coef_idx  = idx_q;
    assign coef_last = (idx_q == IDX_W'(N_COEF - 1));
    assign busy      = run;
    assign done      = (state_q == DONE);
    assign err       = err_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> RUN on legal start, RUN -> DONE on last coef.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (coef_hs && coef_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Configuration latch, word/coef counters and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitlen_q <= '0;
            mode_q   <= MODE_SIMPLE;
            b_q      <= '0;
            words_q  <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                bitlen_q <= cfg_bitlen;
                mode_q   <= unpack_mode_e'(cfg_mode);
                b_q      <= cfg_b;
                words_q  <= WL_W'(words_per_poly(N_COEF,
                                                 int'(cfg_bitlen),
                                                 IN_W));
                idx_q    <= '0;
                err_q    <= 1'b0;
            end else begin
                if (start_bad) begin
                    err_q <= 1'b1;
                end
                if (word_hs) begin
                    words_q <= words_q - WL_W'(1);
                end
                if (coef_hs) begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (range_bad) begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_bit_unpack.sv
// Directed bench for stream_bit_unpack with immediate assertions.
// Expected coefficients come from raw values the bench packs itself.
module tb_stream_bit_unpack;

    localparam int IN_W       = 32;
    localparam int MAX_BITLEN = 20;
    localparam int COEF_W     = 24;
    localparam int N_COEF     = 256;
    localparam int MAX_WORDS  = N_COEF * MAX_BITLEN / IN_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [4:0]        cfg_bitlen;
    logic              cfg_mode;
    logic [COEF_W-1:0] cfg_b;
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] coef;
    logic [7:0]        coef_idx;
    logic              coef_valid;
    logic              coef_ready;
    logic              coef_last;
    logic              busy;
    logic              done;
    logic              err;

    stream_bit_unpack #(
        .IN_W       (IN_W),
        .MAX_BITLEN (MAX_BITLEN),
        .COEF_W     (COEF_W),
        .N_COEF     (N_COEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_bitlen (cfg_bitlen),
        .cfg_mode   (cfg_mode),
        .cfg_b      (cfg_b),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coef       (coef),
        .coef_idx   (coef_idx),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_last  (coef_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [MAX_BITLEN-1:0] raw_vals [N_COEF];
    logic [IN_W-1:0]       words [MAX_WORDS];
    int                    words_used;
    int                    lat;
    logic [COEF_W-1:0]     c5;
    logic [COEF_W-1:0]     c8;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack(input int bl);
        logic [N_COEF*MAX_BITLEN-1:0] s;
        s = '0;
        for (int i = 0; i < N_COEF; i++)
            for (int j = 0; j < bl; j++)
                s[i*bl+j] = raw_vals[i][j];
        for (int w = 0; w < MAX_WORDS; w++)
            words[w] = s[w*IN_W +: IN_W];
    endtask

    task automatic do_start(input int bl, input logic mode,
                            input logic [COEF_W-1:0] b);
        @(negedge clk);
        cfg_bitlen = 5'(bl);
        cfg_mode   = mode;
        cfg_b      = b;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cfg_bitlen = 5'd7;
        cfg_mode   = ~mode;
        cfg_b      = 24'h000123;
    endtask

    task automatic run_poly(input int bl, input logic mode,
                            input logic [COEF_W-1:0] b,
                            input int gap_pct, input int stall_pct,
                            input int stop_at);
        int wi = 0;
        int ei = 0;
        int cyc = 0;
        int fw = -1;
        int fv = -1;
        int nw;
        bit stalled = 0;
        logic [COEF_W-1:0] held_coef = '0;
        logic [7:0]        held_idx = '0;
        logic [COEF_W-1:0] exp;
        nw = N_COEF * bl / IN_W;
        while (ei < N_COEF && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (stop_at >= 0 && coef_valid && coef_idx == 8'(stop_at))
                break;
            in_valid   = (wi < nw) && ($urandom_range(99) >= gap_pct);
            in_data    = in_valid ? words[wi] : 32'hDEADBEEF;
            coef_ready = ($urandom_range(99) >= stall_pct);
            if (stalled) begin
                chk("hold_valid", 32'(coef_valid), 32'd1);
                chk("hold_coef", 32'(coef), 32'(held_coef));
                chk("hold_idx", 32'(coef_idx), 32'(held_idx));
            end
            if (in_valid && in_ready) begin
                if (fw < 0) fw = cyc;
                wi++;
            end
            if (coef_valid && fv < 0) fv = cyc;
            if (coef_valid) begin
                stalled   = !coef_ready;
                held_coef = coef;
                held_idx  = coef_idx;
                if (coef_ready) begin
                    exp = {4'b0, raw_vals[ei]};
                    if (mode) exp = b - exp;
                    if (ei == 5) c5 = coef;
                    if (ei == 8) c8 = coef;
                    chk("coef", 32'(coef), 32'(exp));
                    chk("idx", 32'(coef_idx), 32'(ei));
                    chk("last", 32'(coef_last), 32'(ei == N_COEF - 1));
                    ei++;
                end
            end else begin
                stalled = 0;
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (stop_at < 0) chk("coef_count", 32'(ei), 32'(N_COEF));
        words_used = wi;
        lat = fv - fw;
    endtask

    task automatic post_done();
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_valid", 32'(coef_valid), 32'd0);
        @(negedge clk);
        chk("done_drop", 32'(done), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        cfg_bitlen = '0;
        cfg_mode   = 1'b0;
        cfg_b      = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        coef_ready = 1'b0;
        c5         = '0;
        c8         = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(coef_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_coef", 32'(coef), 32'd0);
        chk("rst_idx", 32'(coef_idx), 32'd0);
        chk("rst_last", 32'(coef_last), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // simple mode ramp, bitlen 10, full throughput
        for (int i = 0; i < N_COEF; i++) raw_vals[i] = 20'(i);
        pack(10);
        do_start(10, 1'b0, 24'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        run_poly(10, 1'b0, 24'd0, 0, 0, -1);
        chk("t1_words", 32'(words_used), 32'd80);
        chk("t1_latency", 32'(lat), 32'd1);
        post_done();

        // subtract mode, bitlen 4, b 4, raw 0..8; stray start mid-run
        for (int i = 0; i < N_COEF; i++) raw_vals[i] = 20'(i % 9);
        pack(4);
        do_start(4, 1'b1, 24'd4);
        start      = 1'b1;
        cfg_bitlen = 5'd7;
        @(negedge clk);
        start      = 1'b0;
        chk("t2_busy", 32'(busy), 32'd1);
        run_poly(4, 1'b1, 24'd4, 0, 0, -1);
        chk("t2_words", 32'(words_used), 32'd32);
        chk("t2_neg4", 32'(c8), 32'h00FFFFFC);
        post_done();

        // bitlen 20, random data, input gaps, 50% output stalls
        for (int i = 0; i < N_COEF; i++) raw_vals[i] = 20'($urandom);
        pack(20);
        do_start(20, 1'b0, 24'd0);
        run_poly(20, 1'b0, 24'd0, 30, 50, -1);
        chk("t3_words", 32'(words_used), 32'd160);
        post_done();
        chk("t3_err", 32'(err), 32'd0);

        // illegal bit lengths, then a legal start clears err
        do_start(0, 1'b0, 24'd0);
        chk("t4_err0", 32'(err), 32'd1);
        chk("t4_busy0", 32'(busy), 32'd0);
        do_start(21, 1'b0, 24'd0);
        chk("t4_err21", 32'(err), 32'd1);
        chk("t4_busy21", 32'(busy), 32'd0);
        for (int i = 0; i < N_COEF; i++) raw_vals[i] = 20'(i % 8);
        pack(3);
        do_start(3, 1'b1, 24'd2);
        chk("t4_err_clr", 32'(err), 32'd0);
        chk("t4_busy3", 32'(busy), 32'd1);
        run_poly(3, 1'b1, 24'd2, 0, 0, -1);
        chk("t4_words", 32'(words_used), 32'd24);
        chk("t4_neg3", 32'(c5), 32'h00FFFFFD);
        post_done();
`ifdef UNPACK_RANGE_CHECK_EN
        chk("t4_range_err", 32'(err), 32'd1);
`else
        chk("t4_range_err", 32'(err), 32'd0);
`endif

        // reset at coef_idx 100, then a fresh polynomial
        for (int i = 0; i < N_COEF; i++) raw_vals[i] = 20'($urandom & 32'h1FFF);
        pack(13);
        do_start(13, 1'b0, 24'd0);
        run_poly(13, 1'b0, 24'd0, 10, 20, 100);
        chk("t5_reached100", 32'(coef_idx), 32'd100);
        reset = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(coef_valid), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t5_rst_idx", 32'(coef_idx), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N_COEF; i++)
            raw_vals[i] = 20'((i * 37 + 11) & 32'h1FFF);
        pack(13);
        do_start(13, 1'b0, 24'd0);
        run_poly(13, 1'b0, 24'd0, 10, 20, -1);
        chk("t5_words", 32'(words_used), 32'd104);
        post_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_bit_unpack.md
Name: stream_bit_unpack

Overview:
- Streaming, runtime-configurable successor to the flat combinational coefficient unpacker.
- Accepts a packed byte string as IN_W-bit words over a valid/ready stream and emits N_COEF polynomial coefficients, one per handshake.
- Two modes: SimpleBitUnpack (coef = raw bits) and BitUnpack (coef = b - raw, signed).
- Sits between the byte-string input buffer (pk/sig decode path) and the NTT/polynomial RAM writer.

Parameters:
- IN_W, 32, input word width in bits; must be a multiple of 8.
- MAX_BITLEN, 20, largest supported coefficient bit length.
- COEF_W, 24, output coefficient width in bits (two's complement in BitUnpack mode).
- N_COEF, 256, coefficients per polynomial.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches configuration and begins a polynomial
- cfg_bitlen  in  $clog2(MAX_BITLEN+1)  coefficient bit length, legal range 1..MAX_BITLEN
- cfg_mode  in  1  0 = simple, 1 = subtract-from-b
- cfg_b  in  COEF_W  b value used in mode 1
- in_data  in  IN_W  packed word, LSB-first bit order
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts in_data this cycle
- coef  out  COEF_W  unpacked coefficient
- coef_idx  out  $clog2(N_COEF)  index of coef
- coef_valid  out  1  coef valid
- coef_ready  in  1  downstream accepts coef
- coef_last  out  1  coef_idx == N_COEF-1
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last coef handshake
- err  out  1  sticky error; cleared by the next legal start

Behaviour:
- Reset values: all outputs 0; state IDLE; bit buffer empty; counters 0.
- States:
  - IDLE: on start with a legal cfg_bitlen, latch configuration, clear counters and err, go to RUN.
  - IDLE, illegal start: cfg_bitlen = 0 or > MAX_BITLEN sets err and stays in IDLE.
  - RUN: on the handshake of the coef with coef_last, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- Configuration: latched at start; later changes to cfg_* are ignored until the next start.
- start while not IDLE is ignored and has no effect.
- Bit buffer: IN_W+MAX_BITLEN-1 bits, with fill count cnt. New words append above the existing cnt bits.
- in_ready = RUN && (cnt + IN_W <= buffer capacity) && (words_left > 0).
- words_left is loaded at start with N_COEF*bitlen/IN_W. Bits are exact, so no residue remains at the end.
- coef_valid = RUN && cnt >= bitlen.
- raw = buffer[bitlen-1:0], zero-extended to COEF_W.
- coef = raw in mode 0; coef = cfg_b - raw, modulo 2^COEF_W, in mode 1.
- Coefficient handshake: shift the buffer right by bitlen and decrement cnt by bitlen.
- Word handshake and coefficient handshake in the same cycle are legal: cnt' = cnt - bitlen + IN_W.
- Output register: coef, coef_idx, coef_last are held stable while coef_valid && !coef_ready.
- Latency: the first coef_valid is registered one cycle after the first word is accepted (bitlen <= IN_W). Steady state is one coef per cycle when both sides stream.
- Extra input: in_valid in IDLE or DONE is not accepted (in_ready = 0).
- Reset mid-operation: asserting reset in any state immediately returns IDLE/empty. Partial polynomial data is discarded.

Optional Feature:
- Macro: UNPACK_RANGE_CHECK_EN.
- Defined: in mode 1, any raw > 2*cfg_b sets err (sticky). The coefficient is still emitted, and the stream is not stalled.
- Undefined: no range check; err reflects only illegal cfg_bitlen.

Decomposition:
- Package athestia_unpack_pkg:
  - unpack_mode_e (MODE_SIMPLE, MODE_SUB_B)
  - unpack_state_e (IDLE, RUN, DONE)
  - default constants for IN_W, MAX_BITLEN, COEF_W, N_COEF
  - function computing words per polynomial
- One sub-module, unpack_shift_buffer: the variable-width append/extract bit buffer, with the cnt register, fill/drain handshakes and simultaneous update.
- The top level holds the FSM, counters, mode arithmetic and output register.

Test Plan:
- Simple mode, bitlen=10, words = 256-coef ramp packed LSB-first (80 words), both sides always ready -> coef_idx 0..255 with coef == idx, coef_last on 255, done one cycle later, in_ready low after word 80.
- BitUnpack mode, bitlen=4, cfg_b=4, raw nibbles 0..8 repeating (32 words) -> coef = 4,3,...,-4 in 24-bit two's complement (-4 = 0xFFFFFC).
- bitlen=20, random coef_ready (50%) and in_valid gaps -> no lost or duplicated coef; coef held stable while stalled; exactly 160 words consumed.
- start with cfg_bitlen=0, then 21 -> err=1, busy stays 0. Legal start with bitlen=3 -> err clears.
- Reset asserted at coef_idx=100 mid-stream, then new start with bitlen=13 -> output sequence restarts at idx 0 with correct values; no stale bits.
- With UNPACK_RANGE_CHECK_EN, mode 1, cfg_b=2, bitlen=3, raw=5 -> err=1, coef=-3 still emitted. Without the macro -> err stays 0.
